core_mem_arbiter: RTL and testbench
===================================

# core_mem_arbiter

Round-robin arbiter that lets NUM_CORES processor cores share one data-memory port. It is the parametrised successor of the single-core memory hookup: each core gets a valid/ready request channel and a response pulse, and the memory side gets one request/accept/response handshake with variable latency. It sits between the cores' load/store paths and the shared data memory (or cache controller) in the multicore top.

## Interface
- NUM_CORES, 2, number of requesting cores (≥2)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_CORES  per-core request valid
- req_ready  out  NUM_CORES  per-core request accepted (one-hot or zero)
- req_wr  in  NUM_CORES  per-core 1 = store, 0 = load
- req_addr  in  NUM_CORES*ADDR_W  packed per-core address, core i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CORES*DATA_W  packed per-core store data
- req_mask  in  NUM_CORES*3  packed per-core access mask (same 3-bit encoding as data memory)
- rsp_valid  out  NUM_CORES  per-core one-cycle response pulse
- rsp_rdata  out  DATA_W  response data, valid with rsp_valid
- mem_req  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_wr, mem_addr, mem_wdata, mem_mask  out  1/ADDR_W/DATA_W/3  latched request fields
- mem_rsp_valid  in  1  memory completion (loads and stores)
- mem_rdata  in  DATA_W  load data, valid with mem_rsp_valid

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. One transaction in flight at a time.
- IDLE: winner = first i with req_valid[i], searching i = rr_ptr, rr_ptr+1, … mod NUM_CORES. req_ready[winner] = 1 combinationally, all others 0. On that edge latch winner index, wr, addr, wdata, mask; go ISSUE. No req_valid: stay IDLE, req_ready = 0.
- ISSUE: mem_req = 1, mem_* driven from latched fields (stable until accepted). mem_ready = 1 → WAIT; else stay ISSUE.
- WAIT: mem_req = 0. mem_rsp_valid = 1 → register mem_rdata into rsp_rdata, go RESP.
- RESP: rsp_valid[grant] = 1 for exactly this cycle; rr_ptr ← (grant+1) mod NUM_CORES; go IDLE.
- Stores complete through the same path; rsp_rdata on a store is whatever mem_rdata carried and is ignored by the core.
- Handshake: transfer occurs when req_valid[i] & req_ready[i]. A core keeps req_valid and fields stable until accepted; it may drop or change req_valid only after acceptance. Cores waiting for rsp_valid stall.
- mem_rsp_valid outside WAIT is ignored. mem_ready outside ISSUE is ignored.
- rsp_rdata holds its value between responses.

## Timing
- Reset (reset = 0, async): state IDLE, rr_ptr = 0, latched fields 0, rsp_rdata = 0; outputs req_ready = 0, rsp_valid = 0, mem_req = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0, mem_mask = 0. Release takes effect at next rising edge.
- Reset mid-transaction abandons it: no rsp_valid is produced; a late mem_rsp_valid is dropped (state not WAIT).
- Minimum latency: accept in cycle 0, mem_req in cycle 1; mem_ready in cycle 1 and mem_rsp_valid in cycle 2 → rsp_valid in cycle 3. Next acceptance earliest cycle 4 (IDLE). Each extra mem_ready or mem_rsp_valid wait cycle adds one cycle.
- Fairness: a continuously requesting core is granted within NUM_CORES transactions.
- mem_rsp_valid in the same cycle as mem_ready is not permitted by the memory protocol; the arbiter only observes mem_rsp_valid from the cycle after acceptance.
- rr_ptr updates only in RESP; a request arriving while not IDLE waits.

## Test plan
- Reset: drive reset = 0 mid-WAIT with req_valid = 2'b11 → all outputs 0 immediately; after release, core 0 accepted first (rr_ptr = 0), no rsp_valid for the abandoned transaction even if mem_rsp_valid pulses.
- Single load, NUM_CORES = 2: core 1 req_valid, addr 0x100, memory ready at once, mem_rdata 0xDEADBEEF one cycle later → req_ready[1] cycle 0, mem_req cycle 1 with mem_addr 0x100, rsp_valid = 2'b10 cycle 3 with rsp_rdata 0xDEADBEEF.
- Round-robin: both cores request continuously, NUM_CORES = 2 → grants alternate 0,1,0,1; with NUM_CORES = 4 and all requesting → 0,1,2,3,0.
- Memory backpressure: mem_ready low 3 cycles, mem_rsp_valid 5 cycles after accept → mem_* stable through ISSUE, rsp_valid exactly once, 1 cycle after mem_rsp_valid; no req_ready in between.
- Store: core 0 store addr 0x40 wdata 0x12345678 mask 3'b010 → mem_wr = 1 with those fields, rsp_valid[0] pulse after ack.
- Spurious inputs: mem_rsp_valid pulsed in IDLE and ISSUE, mem_ready in WAIT → no state change, no rsp_valid.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter that lets NUM_CORES cores share one data-memory port.
// It keeps one transaction in flight: accept, issue, wait for completion, then respond.
module core_mem_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        req_valid,
    output logic [NUM_CORES-1:0]        req_ready,
    input  logic [NUM_CORES-1:0]        req_wr,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
    input  logic [NUM_CORES*3-1:0]      req_mask,
    output logic [NUM_CORES-1:0]        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        mem_req,
    input  logic                        mem_ready,
    output logic                        mem_wr,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic [2:0]                  mem_mask,
    input  logic                        mem_rsp_valid,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IDX_W = $clog2(NUM_CORES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [2:0]        mask;
    } mreq_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_grant;
    mreq_t                r_req;
    logic [DATA_W-1:0]    r_rdata;

    logic                 w_found;
    logic [IDX_W-1:0]     w_win;
    logic [IDX_W-1:0]     w_idx;
    logic [NUM_CORES-1:0] w_win_oh;
    logic [NUM_CORES-1:0] w_grant_oh;
    mreq_t                w_cand;
    logic                 w_accept;

    // Search starts at the round-robin pointer and wraps around the cores.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_idx = IDX_W'((int'(r_rr_ptr) + k) % NUM_CORES);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_cand.wr    = req_wr[w_win];
        w_cand.addr  = req_addr[int'(w_win)*ADDR_W +: ADDR_W];
        w_cand.wdata = req_wdata[int'(w_win)*DATA_W +: DATA_W];
        w_cand.mask  = req_mask[int'(w_win)*3 +: 3];
    end

    assign w_win_oh   = {{(NUM_CORES-1){1'b0}}, 1'b1} << w_win;
    assign w_grant_oh = {{(NUM_CORES-1){1'b0}}, 1'b1} << r_grant;
    assign w_accept   = (r_state == IDLE) && w_found;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_found)       w_state_nx = ISSUE;
            ISSUE:   if (mem_ready)     w_state_nx = WAIT;
            WAIT:    if (mem_rsp_valid) w_state_nx = RESP;
            RESP:                       w_state_nx = IDLE;
            default:                    w_state_nx = IDLE;
        endcase
    end

    // req_ready is gated by reset so an asserted reset silences it immediately.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (w_accept && reset)  req_ready = w_win_oh;
        if (r_state == RESP)    rsp_valid = w_grant_oh;
    end

    assign mem_req   = (r_state == ISSUE);
    assign mem_wr    = r_req.wr;
    assign mem_addr  = r_req.addr;
    assign mem_wdata = r_req.wdata;
    assign mem_mask  = r_req.mask;
    assign rsp_rdata = r_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_req    <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) begin
                r_grant <= w_win;
                r_req   <= w_cand;
            end
            if ((r_state == WAIT) && mem_rsp_valid)
                r_rdata <= mem_rdata;
            if (r_state == RESP)
                r_rr_ptr <= (r_grant == IDX_W'(NUM_CORES-1)) ? '0 : r_grant + 1'b1;
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: a 2-core instance driven step by step, plus a
// 4-core instance with an always-ready memory for the rotation order.
module tb_core_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  rv, rr, wr, rsp;
    logic [63:0] addr, wdata;
    logic [5:0]  mask;
    logic [31:0] rdata, maddr, mwdata, mrd;
    logic [2:0]  mmask;
    logic        mreq, mr, mwr, mrv;

    logic [3:0]   rv4, rr4, rsp4;
    logic [3:0]   wr4 = 4'b0;
    logic [127:0] addr4 = '0, wdata4 = '0;
    logic [11:0]  mask4 = '0;
    logic [31:0]  rdata4, maddr4, mwdata4;
    logic [31:0]  mrd4 = 32'h4444_0000;
    logic [2:0]   mmask4;
    logic         mreq4, mr4, mwr4;
    logic         mrv4 = 1'b0;

    core_mem_arbiter #(.NUM_CORES(2), .ADDR_W(32), .DATA_W(32)) u2 (
        .clk(clk), .reset(reset), .req_valid(rv), .req_ready(rr), .req_wr(wr),
        .req_addr(addr), .req_wdata(wdata), .req_mask(mask), .rsp_valid(rsp),
        .rsp_rdata(rdata), .mem_req(mreq), .mem_ready(mr), .mem_wr(mwr),
        .mem_addr(maddr), .mem_wdata(mwdata), .mem_mask(mmask),
        .mem_rsp_valid(mrv), .mem_rdata(mrd));

    core_mem_arbiter #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32)) u4 (
        .clk(clk), .reset(reset), .req_valid(rv4), .req_ready(rr4), .req_wr(wr4),
        .req_addr(addr4), .req_wdata(wdata4), .req_mask(mask4), .rsp_valid(rsp4),
        .rsp_rdata(rdata4), .mem_req(mreq4), .mem_ready(mr4), .mem_wr(mwr4),
        .mem_addr(maddr4), .mem_wdata(mwdata4), .mem_mask(mmask4),
        .mem_rsp_valid(mrv4), .mem_rdata(mrd4));

    // Memory for the 4-core instance: accepts at once, completes one cycle later.
    assign mr4 = mreq4;
    always @(posedge clk) mrv4 <= mreq4 & mr4;

    typedef struct { logic [1:0] oh; logic [31:0] data; } exp_t;
    exp_t       q[$];
    logic [3:0] q4[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Caller is at the IDLE-cycle negedge with the request driven.
    task automatic txn(input string tag, input logic [1:0] oh, input logic ewr,
                       input logic [31:0] ea, input logic [31:0] ew, input logic [2:0] em,
                       input logic [31:0] rd, input int rw, input int sw,
                       input bit spur, input bit keep);
        exp_t e;
        #1;
        chk({tag, ":ready"}, 64'(rr), 64'(oh));
        chk({tag, ":idle_rsp"}, 64'(rsp), 64'h0);
        e.oh = oh; e.data = rd;
        q.push_back(e);
        for (int i = 0; i <= rw; i++) begin
            @(negedge clk);
            if (i == 0 && !keep) rv = rv & ~oh;
            mr  = (i == rw);
            mrv = spur && (i == 0) && (rw > 0);
            #1;
            chk({tag, ":mem_req"}, 64'(mreq), 64'h1);
            chk({tag, ":mem_addr"}, 64'(maddr), 64'(ea));
            chk({tag, ":mem_wr"}, 64'(mwr), 64'(ewr));
            chk({tag, ":mem_wdata"}, 64'(mwdata), 64'(ew));
            chk({tag, ":mem_mask"}, 64'(mmask), 64'(em));
            chk({tag, ":busy_ready"}, 64'(rr), 64'h0);
        end
        for (int i = 0; i <= sw; i++) begin
            @(negedge clk);
            mr  = spur && (i == 0) && (sw > 0);
            mrv = (i == sw);
            mrd = (i == sw) ? rd : (32'hBAD0_0000 | 32'(i));
            #1;
            chk({tag, ":wait_req"}, 64'(mreq), 64'h0);
            chk({tag, ":wait_rsp"}, 64'(rsp), 64'h0);
        end
        @(negedge clk);
        mr = 1'b0; mrv = 1'b0;
        #1;
        e = q.pop_front();
        chk({tag, ":rsp_valid"}, 64'(rsp), 64'(e.oh));
        chk({tag, ":rsp_rdata"}, 64'(rdata), 64'(e.data));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ":ready"}, 64'(rr), 64'h0);
        chk({tag, ":rsp"}, 64'(rsp), 64'h0);
        chk({tag, ":mem_req"}, 64'(mreq), 64'h0);
        chk({tag, ":mem_wr"}, 64'(mwr), 64'h0);
        chk({tag, ":mem_addr"}, 64'(maddr), 64'h0);
        chk({tag, ":mem_wdata"}, 64'(mwdata), 64'h0);
        chk({tag, ":mem_mask"}, 64'(mmask), 64'h0);
        chk({tag, ":rdata"}, 64'(rdata), 64'h0);
    endtask

    int n;

    initial begin
        reset = 1'b0; rv = 2'b11; wr = '0; addr = '0; wdata = '0; mask = '0;
        mr = 1'b0; mrv = 1'b0; mrd = '0; rv4 = '0;
        #1;
        chk_zero("por");
        chk("por:rsp4", 64'(rsp4), 64'h0);
        @(negedge clk); rv = 2'b00; reset = 1'b1;

        // completion and data while idle must be ignored
        @(negedge clk); mrv = 1'b1; mrd = 32'h5555_5555;
        #1; chk("spur_idle:ready", 64'(rr), 64'h0); chk("spur_idle:req", 64'(mreq), 64'h0);
        @(negedge clk); mrv = 1'b0;
        #1; chk("spur_idle:rsp", 64'(rsp), 64'h0); chk("spur_idle:rdata", 64'(rdata), 64'h0);

        @(negedge clk);
        rv = 2'b01; wr = 2'b01; addr[31:0] = 32'h40; wdata[31:0] = 32'h1234_5678; mask[2:0] = 3'b010;
        txn("store", 2'b01, 1'b1, 32'h40, 32'h1234_5678, 3'b010, 32'hCAFE_0001, 1, 1, 1'b1, 1'b0);

        @(negedge clk);
        rv = 2'b10; addr[63:32] = 32'h100;
        txn("load", 2'b10, 1'b0, 32'h100, 32'h0, 3'b000, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk("hold:rdata", 64'(rdata), 64'hDEAD_BEEF);
        chk("hold:rsp", 64'(rsp), 64'h0);

        @(negedge clk);
        wr = 2'b00; addr[31:0] = 32'h200; wdata[31:0] = 32'h0; mask[2:0] = 3'b100; rv = 2'b11;
        txn("rr0", 2'b01, 1'b0, 32'h200, 32'h0, 3'b100, 32'h0000_00A0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        txn("rr1", 2'b10, 1'b0, 32'h100, 32'h0, 3'b000, 32'h0000_00A1, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        txn("rr2", 2'b01, 1'b0, 32'h200, 32'h0, 3'b100, 32'h0000_00A2, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        txn("rr3", 2'b10, 1'b0, 32'h100, 32'h0, 3'b000, 32'h0000_00A3, 0, 0, 1'b0, 1'b0);
        rv = 2'b00;

        @(negedge clk);
        rv = 2'b01;
        txn("bp", 2'b01, 1'b0, 32'h200, 32'h0, 3'b100, 32'h0B0B_0B0B, 3, 4, 1'b0, 1'b0);

        // pointer now at core 1; abandon its transaction with a reset in WAIT
        @(negedge clk); rv = 2'b11;
        #1; chk("abort:ready", 64'(rr), 64'h2);
        @(negedge clk); mr = 1'b1;
        #1; chk("abort:mem_req", 64'(mreq), 64'h1); chk("abort:mem_addr", 64'(maddr), 64'h100);
        @(negedge clk); mr = 1'b0;
        #1; chk("abort:wait", 64'(mreq), 64'h0);
        @(negedge clk); reset = 1'b0;
        #1; chk_zero("rst");
        @(negedge clk); mrv = 1'b1; mrd = 32'h7777_7777;
        #1; chk("rst:late_rsp", 64'(rsp), 64'h0); chk("rst:late_ready", 64'(rr), 64'h0);
        @(negedge clk); reset = 1'b1;
        txn("post_rst", 2'b01, 1'b0, 32'h200, 32'h0, 3'b100, 32'h0C0C_0C0C, 0, 0, 1'b0, 1'b0);
        rv = 2'b00;

        @(negedge clk);
        rv4 = 4'hF;
        q4.push_back(4'b0001); q4.push_back(4'b0010); q4.push_back(4'b0100);
        q4.push_back(4'b1000); q4.push_back(4'b0001);
        for (int t = 0; t < 5; t++) begin
            n = 0;
            do begin
                @(negedge clk); #1; n++;
            end while (rsp4 == 4'b0 && n < 20);
            chk("rr4", 64'(rsp4), 64'(q4.pop_front()));
        end
        rv4 = 4'h0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
